// File: rtl/vote_session_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vote_session_ctrl: voting-window sequencer for the 7-input majority voter. |
// | Optional MISMATCH self-check enabled by defining VOTE_CHECK_EN.            |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module vote_session_ctrl #(
   parameter int WINDOW = 16,
   parameter int SETTLE = 2
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       START,
   input  logic [6:0] VOTE_YES,
   input  logic [6:0] VOTE_NO,
   output logic [6:0] A_DRV,
   input  logic       VOTER_OUT,
   output logic [6:0] VOTED,
   output logic [2:0] YES_CNT,
   output logic       BUSY,
   output logic       DONE,
   output logic       PASS
`ifdef VOTE_CHECK_EN
   ,
   output logic       MISMATCH
`endif
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_OPEN   = 2'd1,
      S_EVAL   = 2'd2,
      S_RESULT = 2'd3
   } state_t;

   state_t     r_state,   w_state_nxt;
   logic [7:0] r_win_cnt, w_win_nxt;
   logic [3:0] r_set_cnt, w_set_nxt;
   logic [6:0] r_voted,   w_voted_nxt;
   logic [6:0] r_yes,     w_yes_nxt;
   logic [2:0] r_yes_cnt, w_yes_cnt_nxt;
   logic       r_pass,    w_pass_nxt;
   logic       r_done,    w_done_nxt;
   logic [6:0] w_acc_yes;
   logic [6:0] w_acc_no;
`ifdef VOTE_CHECK_EN
   logic       r_mismatch, w_mismatch_nxt;
`endif

   function automatic logic [2:0] f_popcnt(input logic [6:0] v);
      logic [2:0] s;
      s = 3'd0;
      for (int i = 0; i < 7; i++) begin
         s = s + {2'b00, v[i]};
      end
      return s;
   endfunction

   // A simultaneous yes+no from one voter is dropped so that voter may retry.
   assign w_acc_yes = VOTE_YES & ~VOTE_NO & ~r_voted;
   assign w_acc_no  = VOTE_NO & ~VOTE_YES & ~r_voted;

   always_comb begin
      w_state_nxt   = r_state;
      w_win_nxt     = r_win_cnt;
      w_set_nxt     = r_set_cnt;
      w_voted_nxt   = r_voted;
      w_yes_nxt     = r_yes;
      w_yes_cnt_nxt = r_yes_cnt;
      w_pass_nxt    = r_pass;
      w_done_nxt    = 1'b0;
`ifdef VOTE_CHECK_EN
      w_mismatch_nxt = r_mismatch;
`endif
      case (r_state)
         S_IDLE, S_RESULT: begin
            if (START) begin
               w_state_nxt   = S_OPEN;
               w_voted_nxt   = 7'h00;
               w_yes_nxt     = 7'h00;
               w_yes_cnt_nxt = 3'd0;
               w_win_nxt     = 8'(WINDOW - 1);
`ifdef VOTE_CHECK_EN
               w_mismatch_nxt = 1'b0;
`endif
            end
         end
         S_OPEN: begin
            w_voted_nxt   = r_voted | w_acc_yes | w_acc_no;
            w_yes_nxt     = r_yes | w_acc_yes;
            w_yes_cnt_nxt = r_yes_cnt + f_popcnt(w_acc_yes);
            if ((w_voted_nxt == 7'h7F) || (r_win_cnt == 8'd0)) begin
               w_state_nxt = S_EVAL;
               w_set_nxt   = 4'(SETTLE - 1);
            end else begin
               w_win_nxt = r_win_cnt - 8'd1;
            end
         end
         S_EVAL: begin
            if (r_set_cnt == 4'd0) begin
               w_state_nxt = S_RESULT;
               w_pass_nxt  = VOTER_OUT;
               w_done_nxt  = 1'b1;
`ifdef VOTE_CHECK_EN
               w_mismatch_nxt = (VOTER_OUT != (r_yes_cnt >= 3'd4));
`endif
            end else begin
               w_set_nxt = r_set_cnt - 4'd1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= S_IDLE;
         r_win_cnt <= 8'd0;
         r_set_cnt <= 4'd0;
         r_voted   <= 7'h00;
         r_yes     <= 7'h00;
         r_yes_cnt <= 3'd0;
         r_pass    <= 1'b0;
         r_done    <= 1'b0;
`ifdef VOTE_CHECK_EN
         r_mismatch <= 1'b0;
`endif
      end else begin
         r_state   <= w_state_nxt;
         r_win_cnt <= w_win_nxt;
         r_set_cnt <= w_set_nxt;
         r_voted   <= w_voted_nxt;
         r_yes     <= w_yes_nxt;
         r_yes_cnt <= w_yes_cnt_nxt;
         r_pass    <= w_pass_nxt;
         r_done    <= w_done_nxt;
`ifdef VOTE_CHECK_EN
         r_mismatch <= w_mismatch_nxt;
`endif
      end
   end

   // Non-voters present as 0 to the datapath; lines are parked low when idle.
   assign A_DRV   = (r_state == S_IDLE) ? 7'h00 : r_yes;
   assign VOTED   = r_voted;
   assign YES_CNT = r_yes_cnt;
   assign BUSY    = (r_state == S_OPEN) || (r_state == S_EVAL);
   assign DONE    = r_done;
   assign PASS    = r_pass;
`ifdef VOTE_CHECK_EN
   assign MISMATCH = r_mismatch;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vote_session_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vote_session_ctrl: directed and random checks against a session model.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_vote_session_ctrl;

   localparam int WINDOW = 16;
   localparam int SETTLE = 2;
   localparam int P_IDLE = 0, P_OPEN = 1, P_EVAL = 2, P_RESULT = 3;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       START = 1'b0;
   logic [6:0] VOTE_YES = 7'h00;
   logic [6:0] VOTE_NO = 7'h00;
   logic [6:0] A_DRV;
   logic       VOTER_OUT;
   logic [6:0] VOTED;
   logic [2:0] YES_CNT;
   logic       BUSY;
   logic       DONE;
   logic       PASS;
`ifdef VOTE_CHECK_EN
   logic       MISMATCH;
`endif

   logic force_en = 1'b0;
   logic force_val = 1'b0;

   int n_assert = 0;
   int n_fail = 0;
   int cyc = 0;

   // Model of the session as seen from outside.
   int         m_phase = P_IDLE;
   logic [6:0] m_voted = 7'h00;
   logic [6:0] m_yesl = 7'h00;
   int         m_cnt = 0;
   int         m_open = 0;
   int         m_eval = 0;
   logic       m_pass = 1'b0;
   logic       m_done = 1'b0;
   logic       m_mism = 1'b0;

   // Majority voter stand-in, with an override for fault injection.
   assign VOTER_OUT = force_en ? force_val : ($countones(A_DRV) >= 4);

   vote_session_ctrl #(.WINDOW(WINDOW), .SETTLE(SETTLE)) dut (
      .CLK(CLK), .RST(RST), .START(START), .VOTE_YES(VOTE_YES), .VOTE_NO(VOTE_NO),
      .A_DRV(A_DRV), .VOTER_OUT(VOTER_OUT), .VOTED(VOTED), .YES_CNT(YES_CNT),
      .BUSY(BUSY), .DONE(DONE), .PASS(PASS)
`ifdef VOTE_CHECK_EN
      , .MISMATCH(MISMATCH)
`endif
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic int ones7(input logic [6:0] v);
      int s = 0;
      for (int i = 0; i < 7; i++) s += int'(v[i]);
      return s;
   endfunction

   task automatic model_edge();
      logic v;
      v = force_en ? force_val : (ones7(m_yesl) >= 4);
      if (RST) begin
         m_phase = P_IDLE; m_voted = 7'h00; m_yesl = 7'h00; m_cnt = 0;
         m_pass = 1'b0; m_done = 1'b0; m_mism = 1'b0;
      end else begin
         m_done = 1'b0;
         case (m_phase)
            P_IDLE, P_RESULT: if (START) begin
               m_phase = P_OPEN; m_voted = 7'h00; m_yesl = 7'h00;
               m_cnt = 0; m_open = 0; m_mism = 1'b0;
            end
            P_OPEN: begin
               for (int i = 0; i < 7; i++) begin
                  if (!m_voted[i] && (VOTE_YES[i] != VOTE_NO[i])) begin
                     m_voted[i] = 1'b1;
                     if (VOTE_YES[i]) begin
                        m_yesl[i] = 1'b1;
                        m_cnt++;
                     end
                  end
               end
               m_open++;
               if (m_voted == 7'h7F || m_open == WINDOW) begin
                  m_phase = P_EVAL;
                  m_eval = 0;
               end
            end
            default: begin
               m_eval++;
               if (m_eval == SETTLE) begin
                  m_pass = v;
                  m_mism = (v != (m_cnt >= 4));
                  m_done = 1'b1;
                  m_phase = P_RESULT;
               end
            end
         endcase
      end
   endtask

   task automatic check_all();
      chk("a_drv", {1'b0, A_DRV}, {1'b0, (m_phase == P_IDLE) ? 7'h00 : m_yesl});
      chk("voted", {1'b0, VOTED}, {1'b0, m_voted});
      chk("yes_cnt", {5'd0, YES_CNT}, 8'(m_cnt));
      chk("busy", {7'd0, BUSY}, {7'd0, (m_phase == P_OPEN || m_phase == P_EVAL)});
      chk("done", {7'd0, DONE}, {7'd0, m_done});
      chk("pass", {7'd0, PASS}, {7'd0, m_pass});
`ifdef VOTE_CHECK_EN
      chk("mismatch", {7'd0, MISMATCH}, {7'd0, m_mism});
`endif
   endtask

   task automatic step(input logic st, input logic [6:0] y, input logic [6:0] n);
      START = st; VOTE_YES = y; VOTE_NO = n;
      model_edge();
      @(posedge CLK);
      #1;
      cyc++;
      START = 1'b0; VOTE_YES = 7'h00; VOTE_NO = 7'h00;
      check_all();
   endtask

   task automatic wait_done(input string tag);
      int k = 0;
      while (DONE !== 1'b1 && k < 40) begin
         step(1'b0, 7'h00, 7'h00);
         k++;
      end
      chk({tag, "_done_seen"}, {7'd0, DONE}, 8'd1);
   endtask

   initial begin
      int st_cyc;
      // Reset, then abort a session mid-OPEN with a 3-cycle reset.
      RST = 1'b1;
      step(1'b0, 7'h00, 7'h00);
      step(1'b0, 7'h00, 7'h00);
      RST = 1'b0;
      step(1'b1, 7'h00, 7'h00);
      step(1'b0, 7'h01, 7'h02);
      RST = 1'b1;
      for (int i = 0; i < 3; i++) step(1'b0, 7'h04, 7'h00);
      RST = 1'b0;
      step(1'b0, 7'h00, 7'h00);
      chk("rst_a_drv", {1'b0, A_DRV}, 8'h00);
      chk("rst_voted", {1'b0, VOTED}, 8'h00);
      chk("rst_busy", {7'd0, BUSY}, 8'h00);
      step(1'b0, 7'h7F, 7'h00);
      chk("rst_idle_ignores_votes", {1'b0, VOTED}, 8'h00);

      // Three yes, four no: early close.
      step(1'b1, 7'h00, 7'h00);
      step(1'b0, 7'h07, 7'h78);
      chk("t3_busy_eval", {7'd0, BUSY}, 8'h01);
      step(1'b0, 7'h00, 7'h00);
      chk("t3_no_done_yet", {7'd0, DONE}, 8'h00);
      step(1'b0, 7'h00, 7'h00);
      chk("t3_done", {7'd0, DONE}, 8'h01);
      chk("t3_a_drv", {1'b0, A_DRV}, 8'h07);
      chk("t3_yes_cnt", {5'd0, YES_CNT}, 8'h03);
      chk("t3_pass", {7'd0, PASS}, 8'h00);

      // Four yes, window expiry, latency.
      st_cyc = cyc;
      step(1'b1, 7'h00, 7'h00);
      step(1'b0, 7'h55, 7'h00);
      wait_done("t4");
      chk("t4_latency", 8'(cyc - st_cyc), 8'd19);
      chk("t4_a_drv", {1'b0, A_DRV}, 8'h55);
      chk("t4_voted", {1'b0, VOTED}, 8'h55);
      chk("t4_pass", {7'd0, PASS}, 8'h01);

      // Restart from RESULT; PASS holds until the next DONE.
      step(1'b1, 7'h00, 7'h00);
      chk("rs_busy", {7'd0, BUSY}, 8'h01);
      chk("rs_voted", {1'b0, VOTED}, 8'h00);
      chk("rs_yes_cnt", {5'd0, YES_CNT}, 8'h00);
      chk("rs_pass_held", {7'd0, PASS}, 8'h01);

      // Conflicts, duplicates and an ignored START.
      step(1'b0, 7'h03, 7'h02);
      step(1'b1, 7'h00, 7'h03);
      chk("cf_voted", {6'd0, VOTED[1:0]}, 8'h03);
      chk("cf_a0", {7'd0, A_DRV[0]}, 8'h01);
      chk("cf_a1", {7'd0, A_DRV[1]}, 8'h00);
      chk("cf_yes_cnt", {5'd0, YES_CNT}, 8'h01);
      step(1'b1, 7'h00, 7'h00);
      chk("st_ign_voted", {1'b0, VOTED}, 8'h03);
      wait_done("cf");
      chk("cf_pass", {7'd0, PASS}, 8'h00);

      // Forced voter output low with five yes votes.
      force_en = 1'b1; force_val = 1'b0;
      step(1'b1, 7'h00, 7'h00);
      step(1'b0, 7'h1F, 7'h00);
      wait_done("fo");
      chk("fo_pass", {7'd0, PASS}, 8'h00);
`ifdef VOTE_CHECK_EN
      chk("fo_mismatch", {7'd0, MISMATCH}, 8'h01);
      step(1'b1, 7'h00, 7'h00);
      chk("fo_mismatch_clr", {7'd0, MISMATCH}, 8'h00);
`endif
      force_en = 1'b0;

      // Random traffic checked cycle by cycle against the model.
      for (int i = 0; i < 800; i++) begin
         RST = ($urandom_range(0, 199) == 0);
         step(($urandom_range(0, 5) == 0),
              7'($urandom & $urandom & $urandom),
              7'($urandom & $urandom & $urandom));
      end
      RST = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
